// File: rtl/regbank_arbiter.sv
// Round-robin arbiter sharing a register bank between NREQ requesters (one read or
// write per grant), plus a one-register-per-cycle bank-clear sweep.
module regbank_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ*AW-1:0]        req_addr,
  input  logic [NREQ*DW-1:0]        req_wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [DW-1:0]             rdata,
  output logic                      rvalid,
  output logic [$clog2(NREQ)-1:0]   rid,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic [NREG-1:0]           reg_en,
  output logic [DW-1:0]             reg_d,
  input  logic [NREG*DW-1:0]        reg_q
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, ptr_nxt;
  logic [IW-1:0]   win, win_nxt;
  logic            op_wr, op_wr_nxt;
  logic [AW-1:0]   op_addr, op_addr_nxt;
  logic [DW-1:0]   op_wdata, op_wdata_nxt;
  logic [CW-1:0]   clr_idx, clr_idx_nxt;
  logic            clr_pending, clr_pending_nxt;

  logic [NREQ-1:0] gnt_nxt;
  logic [NREG-1:0] reg_en_nxt;
  logic [DW-1:0]   reg_d_nxt;
  logic [DW-1:0]   rdata_nxt;
  logic            rvalid_nxt;
  logic            clr_busy_nxt;
  logic [IW-1:0]   rid_nxt;

  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [DW-1:0]   rd_word;

  // Round-robin search: first active request at or after the pointer
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Operands of the selected requester
  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IW'(i)) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Read mux; addresses beyond the bank read as zero
  always_comb begin
    rd_word = '0;
    for (int r = 0; r < NREG; r++) begin
      if (op_addr == AW'(r)) begin
        rd_word = reg_q[r*DW +: DW];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      op_wr       <= 1'b0;
      op_addr     <= '0;
      op_wdata    <= '0;
      clr_idx     <= '0;
      clr_pending <= 1'b0;
      gnt         <= '0;
      reg_en      <= '0;
      reg_d       <= '0;
      rdata       <= '0;
      rvalid      <= 1'b0;
      rid         <= '0;
      clr_busy    <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      win         <= win_nxt;
      op_wr       <= op_wr_nxt;
      op_addr     <= op_addr_nxt;
      op_wdata    <= op_wdata_nxt;
      clr_idx     <= clr_idx_nxt;
      clr_pending <= clr_pending_nxt;
      gnt         <= gnt_nxt;
      reg_en      <= reg_en_nxt;
      reg_d       <= reg_d_nxt;
      rdata       <= rdata_nxt;
      rvalid      <= rvalid_nxt;
      rid         <= rid_nxt;
      clr_busy    <= clr_busy_nxt;
    end
  end

  // Next state; a clear always beats pending requests in IDLE
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    win_nxt         = win;
    op_wr_nxt       = op_wr;
    op_addr_nxt     = op_addr;
    op_wdata_nxt    = op_wdata;
    clr_idx_nxt     = clr_idx;
    clr_pending_nxt = clr_pending;
    case (state)
      IDLE: begin
        if (clr_pending || clr_start) begin
          state_nxt       = CLEAR;
          clr_idx_nxt     = '0;
          clr_pending_nxt = 1'b0;
        end else if (found) begin
          state_nxt    = GNT;
          win_nxt      = sel;
          op_wr_nxt    = sel_wr;
          op_addr_nxt  = sel_addr;
          op_wdata_nxt = sel_wdata;
        end
      end
      GNT: begin
        state_nxt = IDLE;
        ptr_nxt   = (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
        if (clr_start) clr_pending_nxt = 1'b1;
      end
      CLEAR: begin
        if (clr_start) clr_pending_nxt = 1'b1;
        if (clr_idx == CW'(NREG - 1)) begin
          state_nxt = IDLE;
        end else begin
          clr_idx_nxt = clr_idx + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, registered alongside the state
  always_comb begin
    gnt_nxt      = '0;
    reg_en_nxt   = '0;
    reg_d_nxt    = '0;
    clr_busy_nxt = 1'b0;
    rvalid_nxt   = 1'b0;
    rid_nxt      = rid;
    rdata_nxt    = rdata;
    case (state_nxt)
      GNT: begin
        for (int i = 0; i < NREQ; i++) begin
          gnt_nxt[i] = (win_nxt == IW'(i));
        end
        if (op_wr_nxt) begin
          reg_d_nxt = op_wdata_nxt;
          for (int r = 0; r < NREG; r++) begin
            reg_en_nxt[r] = (op_addr_nxt == AW'(r));
          end
        end
      end
      CLEAR: begin
        clr_busy_nxt = 1'b1;
        for (int r = 0; r < NREG; r++) begin
          reg_en_nxt[r] = (clr_idx_nxt == CW'(r));
        end
      end
      default: ;
    endcase
    if (state == GNT && !op_wr) begin
      rvalid_nxt = 1'b1;
      rid_nxt    = win;
      rdata_nxt  = rd_word;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Scoreboard bench for regbank_arbiter: a transaction-level model predicts the
// grant/sweep sequence and read data; a monitor compares what the DUT presents.
module tb_regbank_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 16;
  localparam bit EV_GRANT = 1'b0;
  localparam bit EV_SWEEP = 1'b1;

  typedef struct {
    bit          kind;
    int          idx;
    bit          wr;
    int          addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          due;
  } rd_t;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     req_wr;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     gnt;
  logic [DW-1:0]       rdata;
  logic                rvalid;
  logic [1:0]          rid;
  logic                clr_start;
  logic                clr_busy;
  logic [NREG-1:0]     reg_en;
  logic [DW-1:0]       reg_d;
  logic [NREG*DW-1:0]  reg_q;

  logic [DW-1:0] bank [NREG] = '{default: '0};
  logic [DW-1:0] mem  [NREG];
  int  m_ptr;
  ev_t evq [$];
  rd_t rdq [$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  sweep_k = 0;
  logic [DW-1:0]   last_rdata = '0;
  logic [NREQ-1:0] prev_gnt = '0;
  ev_t m_e;
  rd_t m_r;

  regbank_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid),
    .clr_start(clr_start), .clr_busy(clr_busy), .reg_en(reg_en), .reg_d(reg_d),
    .reg_q(reg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The register bank the DUT controls
  always @(posedge clk) begin
    for (int r = 0; r < NREG; r++) if (reg_en[r]) bank[r] <= reg_d;
  end
  always_comb begin
    for (int r = 0; r < NREG; r++) reg_q[r*DW +: DW] = bank[r];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_sweep(input bit zero_mem);
    ev_t e;
    e.kind = EV_SWEEP; e.idx = 0; e.wr = 1'b0; e.addr = 0; e.data = '0;
    evq.push_back(e);
    if (zero_mem) for (int r = 0; r < NREG; r++) mem[r] = '0;
  endtask

  // Monitor: pops expectations whenever the DUT grants, sweeps or returns data
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("reset_outs", {gnt, reg_en, rvalid, clr_busy, rid, rdata, reg_d}, 64'h0);
      sweep_k = 0;
      rdq.delete();
      last_rdata = '0;
      prev_gnt = '0;
    end else begin
      if (rvalid) begin
        if (rdq.size() == 0) chk("rvalid_spurious", 1, 0);
        else begin
          m_r = rdq.pop_front();
          chk("rvalid_time", cyc, m_r.due);
          chk("rid", rid, m_r.idx);
          chk("rdata", rdata, m_r.data);
        end
      end else begin
        chk("rdata_hold", rdata, last_rdata);
        if (rdq.size() != 0 && rdq[0].due <= cyc) begin
          chk("rvalid_missing", 0, 1);
          void'(rdq.pop_front());
        end
      end
      last_rdata = rdata;

      if (gnt != '0) begin
        chk("gnt_spacing", prev_gnt, 0);
        chk("gnt_during_clear", clr_busy, 0);
        if (evq.size() == 0) chk("gnt_spurious", gnt, 0);
        else begin
          m_e = evq.pop_front();
          chk("event_is_grant", m_e.kind, EV_GRANT);
          chk("gnt_onehot", gnt, 1 << m_e.idx);
          if (m_e.wr) begin
            chk("wr_reg_en", reg_en, (m_e.addr < NREG) ? (1 << m_e.addr) : 0);
            chk("wr_reg_d", reg_d, m_e.data);
          end else begin
            chk("rd_reg_en", reg_en, 0);
            m_r.idx = m_e.idx; m_r.data = m_e.data; m_r.due = cyc + 1;
            rdq.push_back(m_r);
          end
        end
      end else if (clr_busy) begin
        if (sweep_k == 0) begin
          if (evq.size() == 0) chk("sweep_spurious", 1, 0);
          else begin
            m_e = evq.pop_front();
            chk("event_is_sweep", m_e.kind, EV_SWEEP);
          end
        end
        chk("sweep_reg_en", reg_en, 1 << sweep_k);
        chk("sweep_reg_d", reg_d, 0);
        sweep_k = (sweep_k == NREG - 1) ? 0 : sweep_k + 1;
      end else begin
        chk("quiet_reg_en", reg_en, 0);
        if (sweep_k != 0) begin
          chk("sweep_length", sweep_k, NREG);
          sweep_k = 0;
        end
      end
      prev_gnt = gnt;
    end
  end

  // One round: all masked requesters raise at once and hold until granted.
  // Model: they are served in circular order from the pointer; a clear pulsed in
  // the GNT cycle of grant clr_at (plus optional pulses during that sweep)
  // inserts one or two sweeps right after it.
  task automatic run_round(input logic [3:0] mask, input logic [3:0] wr,
                           input logic [11:0] addr, input logic [63:0] wdata,
                           input bit clr_first, input int clr_at, input bit clr_mid);
    int  order[$];
    int  i, a, seen, busy_cnt, n;
    bit  armed, done;
    ev_t e;
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (mask[i]) order.push_back(i);
    end
    if (clr_first) push_sweep(1'b1);
    for (int j = 0; j < order.size(); j++) begin
      i = order[j];
      a = int'(addr[i*AW +: AW]);
      e.kind = EV_GRANT; e.idx = i; e.wr = wr[i]; e.addr = a;
      if (wr[i]) begin
        e.data = wdata[i*DW +: DW];
        mem[a] = e.data;
      end else begin
        e.data = mem[a];
      end
      evq.push_back(e);
      if (j == clr_at) begin
        push_sweep(1'b1);
        if (clr_mid) push_sweep(1'b1);
      end
    end
    if (order.size() > 0) m_ptr = (order[order.size()-1] + 1) % NREQ;

    req = mask; req_wr = wr; req_addr = addr; req_wdata = wdata;
    clr_start = clr_first;
    seen = 0; busy_cnt = 0; n = 0; armed = 1'b0; done = 1'b0;
    while (!done) begin
      @(negedge clk); #1;
      clr_start = 1'b0;
      if ((gnt & req) != '0) begin
        if (seen == clr_at) begin
          clr_start = 1'b1;
          armed = clr_mid;
        end
        seen++;
        req = req & ~gnt;
      end else if (armed && clr_busy) begin
        busy_cnt++;
        if (busy_cnt == 3 || busy_cnt == 6) clr_start = 1'b1;
      end
      if (req == '0 && !clr_start && evq.size() == 0 && rdq.size() == 0 &&
          !clr_busy && sweep_k == 0) done = 1'b1;
      n++;
      if (!done && n > 300) begin
        chk("round_timeout", n, 0);
        req = '0; clr_start = 1'b0; evq.delete();
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [3:0]  m, w;
    logic [11:0] ad;
    logic [63:0] wd;
    int          ca, n;
    bit          cf, cm;

    reset = 1'b1; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0; clr_start = 1'b0;
    for (int r = 0; r < NREG; r++) mem[r] = '0;
    m_ptr = 0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    #1 chk("idle_outs", {gnt, reg_en, rvalid, clr_busy}, 64'h0);

    // write then read back through requester 0
    run_round(4'b0001, 4'b0001, 12'o0003, {48'h0, 16'hBEEF}, 1'b0, -1, 1'b0);
    run_round(4'b0001, 4'b0000, 12'o0003, 64'h0, 1'b0, -1, 1'b0);

    // fairness: pointer to 0, then 0,1,2,3 / 0,1,2 / 3 before 1
    run_round(4'b1000, 4'b0000, 12'o0000, 64'h0, 1'b0, -1, 1'b0);
    run_round(4'b1111, 4'b0000, 12'o7531, 64'h0, 1'b0, -1, 1'b0);
    run_round(4'b0111, 4'b0000, 12'o0246, 64'h0, 1'b0, -1, 1'b0);
    run_round(4'b1010, 4'b0000, 12'o3030, 64'h0, 1'b0, -1, 1'b0);

    // clear while req1 pends, then read every register
    run_round(4'b1111, 4'b1111, 12'o7654, 64'h1111_2222_3333_4444, 1'b0, -1, 1'b0);
    run_round(4'b0010, 4'b0000, 12'o0070, 64'h0, 1'b1, -1, 1'b0);
    run_round(4'b1111, 4'b0000, 12'o3210, 64'h0, 1'b0, -1, 1'b0);
    run_round(4'b1111, 4'b0000, 12'o7654, 64'h0, 1'b0, -1, 1'b0);

    // clear pulses in a GNT cycle and twice during the sweep
    run_round(4'b1111, 4'b1111, 12'o3210, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, -1, 1'b0);
    run_round(4'b0101, 4'b0000, 12'o0102, 64'h0, 1'b0, 0, 1'b1);
    run_round(4'b1111, 4'b0000, 12'o3210, 64'h0, 1'b0, -1, 1'b0);

    // reset at sweep index 4: registers 0..3 cleared, pointer back to 0
    run_round(4'b1111, 4'b1111, 12'o6420, 64'hDEAD_CAFE_1234_5678, 1'b0, -1, 1'b0);
    run_round(4'b0001, 4'b0001, 12'o0005, {48'h0, 16'h1234}, 1'b0, -1, 1'b0);
    push_sweep(1'b0);
    clr_start = 1'b1;
    @(negedge clk); #1 clr_start = 1'b0;
    n = 0;
    while (reg_en !== 8'h10 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) chk("reach_index4", reg_en, 8'h10);
    reset = 1'b1;
    #1 chk("reset_mid_sweep", {gnt, reg_en, rvalid, clr_busy}, 64'h0);
    for (int r = 0; r < 4; r++) mem[r] = '0;
    m_ptr = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    run_round(4'b0101, 4'b0000, 12'o0502, 64'h0, 1'b0, -1, 1'b0);
    run_round(4'b1111, 4'b0000, 12'o6430, 64'h0, 1'b0, -1, 1'b0);

    // randomized rounds
    for (int r = 0; r < 40; r++) begin
      m  = 4'($urandom_range(1, 15));
      w  = 4'($urandom);
      ad = 12'($urandom);
      wd = {$urandom, $urandom};
      cf = ($urandom_range(0, 7) == 0);
      ca = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, $countones(m) - 1)) : -1;
      cm = ($urandom_range(0, 1) == 1);
      run_round(m, w, ad, wd, cf, ca, cm);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_arbiter.md
Name: regbank_arbiter

Overview:
- Controls a bank of NREG 16-bit enable-gated registers in the Simple CPU datapath.
- Shares the bank between NREQ requesters, such as the fetch/decode unit, the ALU writeback path and the debug port.
- Arbitration is round-robin; each grant performs one read or one write.
- Also runs a sequenced bank-clear sweep that zeroes every register, one per cycle.

Parameters:
NREQ, 4, number of requesters
NREG, 8, number of registers in the bank
AW, 3, register address width
DW, 16, data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester request; must be held until that requester's gnt is sampled
req_wr  in  NREQ  per-requester op: 1 = write, 0 = read
req_addr  in  NREQ*AW  per-requester register address; requester i uses bits [i*AW +: AW]
req_wdata  in  NREQ*DW  per-requester write data; requester i uses bits [i*DW +: DW]
gnt  out  NREQ  one-hot grant, high for exactly one cycle
rdata  out  DW  read data
rvalid  out  1  rdata valid, one-cycle pulse
rid  out  clog2(NREQ)  index of the requester that owns rdata
clr_start  in  1  single-cycle pulse requesting a bank clear
clr_busy  out  1  high while the clear sweep runs
reg_en  out  NREG  one-hot enable to the bank registers
reg_d  out  DW  data to the bank, shared by all registers
reg_q  in  NREG*DW  current contents of the bank

Behaviour:
- Reset:
  - All outputs are 0.
  - State = IDLE, round-robin pointer = 0, clr_pending = 0.
  - Reset mid-operation aborts immediately: any partial clear is abandoned, and no gnt, rvalid or reg_en appears after reset deasserts.
- States: IDLE, GNT, CLEAR.
- IDLE:
  - clr_pending is set, or clr_start is high: go to CLEAR with index = 0. Clear wins over all requests.
  - Otherwise, if any req bit is high: choose the winner by round-robin starting at the pointer. Register the winner's op, address and data, and go to GNT.
  - Otherwise stay in IDLE.
- GNT (exactly one cycle):
  - gnt[winner] = 1.
  - Write: reg_en[addr] = 1 and reg_d = wdata, so the register updates at the end of this cycle.
  - Read: rdata is captured from reg_q[addr] at the end of this cycle. rvalid = 1 and rid = winner during the following cycle.
  - Pointer becomes winner+1, modulo NREQ.
  - Next state is IDLE, so there is at most one grant every 2 cycles.
- CLEAR:
  - clr_busy = 1, reg_en = one-hot(index), reg_d = 0.
  - index increments every cycle. After index NREG-1 the block returns to IDLE, and clr_busy drops in that cycle.
  - The sweep lasts exactly NREG cycles.
  - No grants are issued during CLEAR; requests stay pending.
- clr_start received outside IDLE (in GNT or CLEAR) sets clr_pending. Multiple pulses collapse into one pending clear, which is serviced at the next IDLE.
- A clr_start during CLEAR therefore causes a second full sweep.
- Address out of range (addr >= NREG, possible only when NREG < 2^AW):
  - The request is still granted.
  - A write produces no reg_en.
  - A read returns rdata = 0, still with rvalid = 1.
- reg_en is never multi-hot. reg_en is 0 in IDLE.
- A req dropped before its grant is simply not granted. The arbiter evaluates only in IDLE.
- rdata holds its last value when rvalid = 0.

Test Plan:
- Reset then idle: assert reset for 3 cycles -> gnt, reg_en, rvalid and clr_busy are all 0. Release with no req -> outputs stay 0.
- Single write then read:
  - req0 write, addr 3, data 0xBEEF -> gnt[0] and reg_en = 8'b0000_1000 with reg_d = 0xBEEF in the same cycle.
  - Then req0 read, addr 3 -> rvalid one cycle after gnt, with rdata = 0xBEEF and rid = 0.
- Round-robin fairness: all four req held high with reads -> gnt order 0,1,2,3,0, one grant every 2 cycles. After a grant to 2, with only req1 and req3 high, 3 wins first.
- Clear sweep:
  - clr_start in IDLE while req1 is pending -> clr_busy high for 8 cycles and reg_en walks 1,2,4,...,0x80 with reg_d = 0.
  - gnt[1] follows after the sweep.
  - Reading all 8 registers afterwards returns 0.
- Clear collision: clr_start pulses in a GNT cycle and twice during CLEAR -> each pulse sets clr_pending, so exactly one further sweep follows the running one. No grant appears in between.
- Reset mid-sweep: assert reset at index 4 -> outputs go to 0 immediately. After release there is no reg_en activity and the pointer is back at 0 (req0 wins against req2).
